// File: rtl/matmul_result_writer_if.sv
// Scratchpad write port between the matmul result writer and the scratchpad.
// The writer drives beats as master and the scratchpad answers with ready.
interface matmul_result_writer_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int BUS_WIDTH  = 16
) ();
  logic                  wr_valid;
  logic                  wr_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [BUS_WIDTH-1:0]  wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/matmul_result_writer.sv
// Streams the captured systolic C matrix row-major into the scratchpad, then handshakes done.
// Define WRITER_FLAG_WORD_EN to append one beat carrying the captured PE overflow flags.
module matmul_result_writer #(
  parameter int DATA_WIDTH = 8,
  parameter int BUS_WIDTH  = 16,
  parameter int ADDR_WIDTH = 8,
  localparam int MAX_DIM   = BUS_WIDTH / DATA_WIDTH,
  localparam int N_ELEM    = MAX_DIM * MAX_DIM
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        finish_mul_i,
  input  logic [N_ELEM*BUS_WIDTH-1:0] c_matrix_i,
  input  logic [N_ELEM-1:0]           flags_i,
  input  logic [1:0]                  n_dim_i,
  input  logic [1:0]                  m_dim_i,
  input  logic [ADDR_WIDTH-1:0]       base_addr_i,
  matmul_result_writer_if.master      wr,
  output logic                        finish_write_o,
  output logic                        busy_o,
  output logic                        ovf_o
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
`ifdef WRITER_FLAG_WORD_EN
    , FLAGS
`endif
  } state_e;

  localparam logic [1:0] DIM_MAX = 2'(MAX_DIM - 1);

  state_e                      state_q, state_d;
  logic [N_ELEM*BUS_WIDTH-1:0] c_q, c_sel;
  logic [1:0]                  n_q, m_q, row_q, col_q, row_d, col_d;
  logic [1:0]                  n_clamp, m_clamp;
  logic [ADDR_WIDTH-1:0]       base_q, base_sel;
  logic                        armed_q, load, beat, last_elem;
  logic                        valid_q, valid_d, finish_q, finish_d, busy_q, busy_d;
  logic                        ovf_q, ovf_cap;
  logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
  logic [BUS_WIDTH-1:0]        data_q, data_d;
`ifdef WRITER_FLAG_WORD_EN
  logic [N_ELEM-1:0]           flags_q;
`endif

  assign n_clamp   = (n_dim_i > DIM_MAX) ? DIM_MAX : n_dim_i;
  assign m_clamp   = (m_dim_i > DIM_MAX) ? DIM_MAX : m_dim_i;
  assign beat      = valid_q & wr.wr_ready;
  assign last_elem = (row_q == n_q) && (col_q == m_q);
  // The first beat is produced in the capture cycle, so it must see the raw inputs.
  assign base_sel  = load ? base_addr_i : base_q;
  assign c_sel     = load ? c_matrix_i : c_q;

  always_comb begin
    ovf_cap = 1'b0;
    for (int c = 0; c < MAX_DIM; c++) begin
      for (int r = 0; r < MAX_DIM; r++) begin
        if (r <= int'(n_clamp) && c <= int'(m_clamp)) begin
          ovf_cap = ovf_cap | flags_i[r + c*MAX_DIM];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      finish_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      finish_q <= finish_d;
      busy_q   <= busy_d;
    end
  end

  // A job only starts after finish_mul_i has been seen low, so a level still held
  // high across a reset cannot launch a spurious write-back.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      armed_q <= 1'b0;
      c_q     <= '0;
      n_q     <= '0;
      m_q     <= '0;
      base_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      ovf_q   <= 1'b0;
`ifdef WRITER_FLAG_WORD_EN
      flags_q <= '0;
`endif
    end else begin
      if (!finish_mul_i) begin
        armed_q <= 1'b1;
      end else if (state_q != IDLE) begin
        armed_q <= 1'b0;
      end
      row_q <= row_d;
      col_q <= col_d;
      if (load) begin
        c_q     <= c_matrix_i;
        n_q     <= n_clamp;
        m_q     <= m_clamp;
        base_q  <= base_addr_i;
        ovf_q   <= ovf_cap;
`ifdef WRITER_FLAG_WORD_EN
        flags_q <= flags_i;
`endif
      end
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (finish_mul_i && armed_q) begin
          state_d = WRITE;
          load    = 1'b1;
          row_d   = '0;
          col_d   = '0;
        end
      end
      WRITE: begin
        if (beat) begin
          if (last_elem) begin
`ifdef WRITER_FLAG_WORD_EN
            state_d = FLAGS;
`else
            state_d = DONE;
`endif
          end else if (col_q == m_q) begin
            col_d = '0;
            row_d = row_q + 2'd1;
          end else begin
            col_d = col_q + 2'd1;
          end
        end
      end
`ifdef WRITER_FLAG_WORD_EN
      FLAGS: begin
        if (beat) state_d = DONE;
      end
`endif
      DONE: begin
        if (!finish_mul_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valid_d  = 1'b0;
    addr_d   = '0;
    data_d   = '0;
    busy_d   = (state_d != IDLE);
    finish_d = (state_d == DONE);
    case (state_d)
      WRITE: begin
        valid_d = 1'b1;
        addr_d  = base_sel + ADDR_WIDTH'(int'(row_d) * MAX_DIM + int'(col_d));
        data_d  = c_sel[(int'(col_d) * MAX_DIM + int'(row_d)) * BUS_WIDTH +: BUS_WIDTH];
      end
`ifdef WRITER_FLAG_WORD_EN
      FLAGS: begin
        valid_d = 1'b1;
        addr_d  = base_q + ADDR_WIDTH'(N_ELEM);
        data_d  = BUS_WIDTH'(flags_q);
      end
`endif
      default: ;
    endcase
  end

  assign wr.wr_valid    = valid_q;
  assign wr.wr_addr     = addr_q;
  assign wr.wr_data     = data_q;
  assign finish_write_o = finish_q;
  assign busy_o         = busy_q;
  assign ovf_o          = ovf_q;

endmodule

// File: tb/tb_matmul_result_writer.sv
// Self-checking bench for matmul_result_writer: directed jobs plus random jobs against a
// row-major beat-list model; follows WRITER_FLAG_WORD_EN for the optional flag beat.
module tb_matmul_result_writer;
  localparam int MAX_DIM = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        finish_mul_i;
  logic [63:0] c_matrix_i;
  logic [3:0]  flags_i;
  logic [1:0]  n_dim_i, m_dim_i;
  logic [7:0]  base_addr_i;
  logic        finish_write_o, busy_o, ovf_o;

  int checks = 0;
  int errors = 0;
  logic [15:0] mat [MAX_DIM][MAX_DIM];

  matmul_result_writer_if #(.ADDR_WIDTH(8), .BUS_WIDTH(16)) wr_bus ();

  matmul_result_writer #(.DATA_WIDTH(8), .BUS_WIDTH(16), .ADDR_WIDTH(8)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .finish_mul_i   (finish_mul_i),
    .c_matrix_i     (c_matrix_i),
    .flags_i        (flags_i),
    .n_dim_i        (n_dim_i),
    .m_dim_i        (m_dim_i),
    .base_addr_i    (base_addr_i),
    .wr             (wr_bus),
    .finish_write_o (finish_write_o),
    .busy_o         (busy_o),
    .ovf_o          (ovf_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] base, input logic [1:0] n, input logic [1:0] m,
                               input logic [3:0] flags);
    @(negedge clk_i);
    for (int r = 0; r < MAX_DIM; r++)
      for (int c = 0; c < MAX_DIM; c++)
        c_matrix_i[(c*MAX_DIM + r)*16 +: 16] = mat[r][c];
    flags_i      = flags;
    n_dim_i      = n;
    m_dim_i      = m;
    base_addr_i  = base;
    finish_mul_i = 1'b1;
  endtask

  // mode 0: ready always high, 1: pattern 0,0,1,0,1,..., 2: random ready
  task automatic runJob(input string name, input logic [7:0] base, input logic [1:0] n,
                        input logic [1:0] m, input logic [3:0] flags, input int mode);
    logic [7:0]  exp_addr[$], got_addr[$];
    logic [15:0] exp_data[$], got_data[$];
    logic [7:0]  prev_addr;
    logic [15:0] prev_data;
    logic        exp_ovf, ready, prev_stall, seen_finish;
    int          nc, mc, it, last_beat_it, finish_it;
    nc = (n > 2'd1) ? 1 : int'(n);
    mc = (m > 2'd1) ? 1 : int'(m);
    exp_ovf = 1'b0;
    for (int r = 0; r <= nc; r++) begin
      for (int c = 0; c <= mc; c++) begin
        exp_addr.push_back(base + 8'(r*MAX_DIM + c));
        exp_data.push_back(mat[r][c]);
        exp_ovf = exp_ovf | flags[r + c*MAX_DIM];
      end
    end
`ifdef WRITER_FLAG_WORD_EN
    exp_addr.push_back(base + 8'(MAX_DIM*MAX_DIM));
    exp_data.push_back({12'h000, flags});
`endif
    applyStimulus(base, n, m, flags);
    it = 0; last_beat_it = -1; finish_it = -1;
    prev_stall = 1'b0; seen_finish = 1'b0; prev_addr = '0; prev_data = '0;
    while (!seen_finish && it < 200) begin
      it++;
      @(negedge clk_i);
      if (it == 1) begin
        checkOutput({name, " first_valid"}, 32'(wr_bus.wr_valid), 32'd1);
        checkOutput({name, " busy"}, 32'(busy_o), 32'd1);
        c_matrix_i  = {$urandom, $urandom};
        base_addr_i = ~base;
        n_dim_i     = ~n;
        m_dim_i     = ~m;
        flags_i     = ~flags;
      end
      if (finish_write_o) begin
        seen_finish = 1'b1;
        finish_it   = it;
        checkOutput({name, " valid_in_done"}, 32'(wr_bus.wr_valid), 32'd0);
      end else begin
        if (prev_stall) begin
          checkOutput({name, " stall_addr"}, 32'(wr_bus.wr_addr), 32'(prev_addr));
          checkOutput({name, " stall_data"}, 32'(wr_bus.wr_data), 32'(prev_data));
        end
        case (mode)
          0:       ready = 1'b1;
          1:       ready = (it <= 2) ? 1'b0 : ((it - 3) % 2 == 0);
          default: ready = 1'($urandom_range(0, 1));
        endcase
        wr_bus.wr_ready = ready;
        if (wr_bus.wr_valid && ready) begin
          got_addr.push_back(wr_bus.wr_addr);
          got_data.push_back(wr_bus.wr_data);
          last_beat_it = it;
        end
        prev_stall = wr_bus.wr_valid && !ready;
        prev_addr  = wr_bus.wr_addr;
        prev_data  = wr_bus.wr_data;
      end
    end
    checkOutput({name, " finish_seen"}, 32'(seen_finish), 32'd1);
    checkOutput({name, " beat_count"}, 32'(got_addr.size()), 32'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      checkOutput($sformatf("%s addr%0d", name, i), 32'(got_addr[i]), 32'(exp_addr[i]));
      checkOutput($sformatf("%s data%0d", name, i), 32'(got_data[i]), 32'(exp_data[i]));
    end
    checkOutput({name, " finish_latency"}, 32'(finish_it), 32'(last_beat_it + 1));
    if (mode == 0) checkOutput({name, " no_bubbles"}, 32'(last_beat_it), 32'(exp_addr.size()));
    checkOutput({name, " ovf"}, 32'(ovf_o), 32'(exp_ovf));
    @(negedge clk_i);
    checkOutput({name, " finish_hold"}, 32'(finish_write_o), 32'd1);
    finish_mul_i = 1'b0;
    @(negedge clk_i);
    checkOutput({name, " finish_drop"}, 32'(finish_write_o), 32'd0);
    checkOutput({name, " idle"}, 32'(busy_o), 32'd0);
    checkOutput({name, " ovf_held"}, 32'(ovf_o), 32'(exp_ovf));
    @(negedge clk_i);
  endtask

  initial begin
    logic spurious;
    rst_ni = 1'b0; finish_mul_i = 1'b0; c_matrix_i = '0; flags_i = '0;
    n_dim_i = '0; m_dim_i = '0; base_addr_i = '0; wr_bus.wr_ready = 1'b0;
    repeat (3) @(negedge clk_i);
    checkOutput("reset valid", 32'(wr_bus.wr_valid), 32'd0);
    checkOutput("reset addr", 32'(wr_bus.wr_addr), 32'd0);
    checkOutput("reset data", 32'(wr_bus.wr_data), 32'd0);
    checkOutput("reset finish", 32'(finish_write_o), 32'd0);
    checkOutput("reset busy", 32'(busy_o), 32'd0);
    checkOutput("reset ovf", 32'(ovf_o), 32'd0);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    mat[0][0] = 16'd1; mat[0][1] = 16'd2; mat[1][0] = 16'd3; mat[1][1] = 16'hFFFC;
    runJob("basic2x2", 8'h10, 2'd1, 2'd1, 4'b0000, 0);
    runJob("row1x2", 8'h20, 2'd0, 2'd1, 4'b0001, 0);
    runJob("backpressure", 8'h40, 2'd1, 2'd1, 4'b1000, 1);
    runJob("wrap", 8'hFE, 2'd1, 2'd1, 4'b0000, 0);
    runJob("flagword", 8'h00, 2'd1, 2'd1, 4'b0100, 0);
    runJob("clamp", 8'h80, 2'd3, 2'd2, 4'b0010, 1);

    // Reset while the second beat is on the bus, with finish_mul_i left high.
    applyStimulus(8'h30, 2'd1, 2'd1, 4'b0000);
    wr_bus.wr_ready = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    checkOutput("rst_mid beat1_addr", 32'(wr_bus.wr_addr), 32'h31);
    rst_ni = 1'b0;
    @(negedge clk_i);
    checkOutput("rst_mid valid", 32'(wr_bus.wr_valid), 32'd0);
    checkOutput("rst_mid busy", 32'(busy_o), 32'd0);
    rst_ni = 1'b1;
    spurious = 1'b0;
    repeat (8) begin
      @(negedge clk_i);
      spurious = spurious | finish_write_o | wr_bus.wr_valid;
    end
    checkOutput("rst_mid no_restart", 32'(spurious), 32'd0);
    finish_mul_i = 1'b0;
    repeat (2) @(negedge clk_i);

    for (int j = 0; j < 8; j++) begin
      for (int r = 0; r < MAX_DIM; r++)
        for (int c = 0; c < MAX_DIM; c++)
          mat[r][c] = 16'($urandom);
      runJob($sformatf("rand%0d", j), 8'($urandom), 2'($urandom_range(0, 3)),
             2'($urandom_range(0, 3)), 4'($urandom), 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
